// File: rtl/neurotransmitter_level_if.sv
// Command/level bundle between one transmitter regulator and its level integrator.
interface neurotransmitter_level_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             inc;
  logic             dec;
  logic             fast;
  logic [WIDTH-1:0] level;
  logic [1:0]       level_q;
  logic             at_max;
  logic             at_min;

  modport master (
    output tick, inc, dec, fast,
    input  level, level_q, at_max, at_min
  );

  modport slave (
    input  tick, inc, dec, fast,
    output level, level_q, at_max, at_min
  );
endinterface

// File: rtl/neurotransmitter_level.sv
// Saturating concentration integrator for one neurotransmitter: prescaled or fast
// inc/dec steps, idle decay toward BASELINE, and a 2-bit quantizer with downward hysteresis.
module neurotransmitter_level #(
  parameter int WIDTH        = 8,
  parameter int BASELINE     = 128,
  parameter int PRESCALE     = 4,
  parameter int STEP_FAST    = 4,
  parameter int DECAY_PERIOD = 16,
  parameter int HYST         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  neurotransmitter_level_if.slave bus
);

  localparam int RW = $clog2(PRESCALE);
  localparam int DW = $clog2(DECAY_PERIOD);
  localparam int T1 = 1 << (WIDTH - 2);
  localparam logic [WIDTH-1:0] LVL_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BASE_L  = WIDTH'(BASELINE);
  localparam logic [1:0] BASE_ZONE = (BASELINE >= 3 * T1) ? 2'd3 :
                                     (BASELINE >= 2 * T1) ? 2'd2 :
                                     (BASELINE >= T1)     ? 2'd1 : 2'd0;

  // Zone threshold T(k) = k * 2^(WIDTH-2); k = 3 still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] zone_thr(input logic [2:0] k);
    return WIDTH'(k) << (WIDTH - 2);
  endfunction

  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [RW-1:0]    rate_q, rate_d, rate_base_s;
  logic [DW-1:0]    decay_q, decay_d;
  logic             dir_q, dir_d;
  logic [1:0]       zone_q, zone_d;
  logic             at_max_q, at_max_d, at_min_q, at_min_d;
  logic             up_s, dn_s, move_up_s;
  logic [WIDTH:0]   step_s, sum_s, diff_s;

  // Command decode, rate/decay counters and saturating level update.
  always_comb begin
    up_s        = bus.inc & ~bus.dec;
    dn_s        = bus.dec & ~bus.inc;
    rate_d      = rate_q;
    decay_d     = decay_q;
    dir_d       = dir_q;
    rate_base_s = rate_q;
    step_s      = '0;
    move_up_s   = 1'b0;
    if (bus.tick) begin
      if (up_s | dn_s) begin
        decay_d   = '0;
        dir_d     = up_s;
        move_up_s = up_s;
        if (bus.fast) begin
          rate_d = '0;
          step_s = (WIDTH + 1)'(STEP_FAST);
        end else begin
          // A direction reversal restarts the prescale count at this tick.
          rate_base_s = (up_s != dir_q) ? '0 : rate_q;
          if (rate_base_s == RW'(PRESCALE - 1)) begin
            rate_d = '0;
            step_s = (WIDTH + 1)'(1);
          end else begin
            rate_d = rate_base_s + RW'(1);
          end
        end
      end else begin
        rate_d    = '0;
        move_up_s = (lvl_q < BASE_L);
        if (decay_q == DW'(DECAY_PERIOD - 1)) begin
          decay_d = '0;
          if (lvl_q != BASE_L) begin
            step_s = (WIDTH + 1)'(1);
          end else begin
            step_s = '0;
          end
        end else begin
          decay_d = decay_q + DW'(1);
        end
      end
    end else begin
      rate_d  = rate_q;
      decay_d = decay_q;
    end

    sum_s  = {1'b0, lvl_q} + step_s;
    diff_s = {1'b0, lvl_q} - step_s;
    if (move_up_s) begin
      lvl_d = sum_s[WIDTH] ? LVL_MAX : sum_s[WIDTH-1:0];
    end else begin
      lvl_d = diff_s[WIDTH] ? '0 : diff_s[WIDTH-1:0];
    end
    at_max_d = (lvl_d == LVL_MAX);
    at_min_d = (lvl_d == '0);
  end

  // Quantizer: one zone step per clk, falling only below T(q) - HYST.
  always_comb begin
    zone_d = zone_q;
    if ((zone_q != 2'd3) && (lvl_q >= zone_thr({1'b0, zone_q} + 3'd1))) begin
      zone_d = zone_q + 2'd1;
    end else if ((zone_q != 2'd0) &&
                 (lvl_q < (zone_thr({1'b0, zone_q}) - WIDTH'(HYST)))) begin
      zone_d = zone_q - 2'd1;
    end else begin
      zone_d = zone_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q    <= BASE_L;
      rate_q   <= '0;
      decay_q  <= '0;
      dir_q    <= 1'b1;
      zone_q   <= BASE_ZONE;
      at_max_q <= (BASE_L == LVL_MAX);
      at_min_q <= (BASE_L == '0);
    end else begin
      lvl_q    <= lvl_d;
      rate_q   <= rate_d;
      decay_q  <= decay_d;
      dir_q    <= dir_d;
      zone_q   <= zone_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  assign bus.level   = lvl_q;
  assign bus.level_q = zone_q;
  assign bus.at_max  = at_max_q;
  assign bus.at_min  = at_min_q;

endmodule

// File: tb/tb_neurotransmitter_level.sv
// Self-checking bench: directed scenarios plus random commands against an integer reference model.
module tb_neurotransmitter_level;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Reference model state (plain integers).
  int m_lvl  = 128;
  int m_cnt  = 0;
  int m_dcnt = 0;
  int m_dir  = 1;
  int m_zone = 2;

  neurotransmitter_level_if #(.WIDTH(8)) bus ();

  neurotransmitter_level dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of one clk edge; the quantizer looks at the level held before the edge.
  task automatic model_edge(input bit r, input bit t, input bit i, input bit d, input bit f);
    int nz, delta, is_up;
    nz = m_zone;
    if (m_zone < 3 && m_lvl >= (m_zone + 1) * 64) nz = m_zone + 1;
    else if (m_zone > 0 && m_lvl < m_zone * 64 - 8) nz = m_zone - 1;
    if (r) begin
      m_lvl = 128; m_cnt = 0; m_dcnt = 0; m_dir = 1; m_zone = 2;
      return;
    end
    if (t) begin
      if (i != d) begin
        is_up = i ? 1 : 0;
        delta = 0;
        m_dcnt = 0;
        if (f) begin
          m_cnt = 0;
          delta = 4;
        end else begin
          if (is_up != m_dir) m_cnt = 0;
          m_cnt++;
          if (m_cnt == 4) begin
            m_cnt = 0;
            delta = 1;
          end
        end
        m_dir = is_up;
        m_lvl = is_up ? m_lvl + delta : m_lvl - delta;
        if (m_lvl > 255) m_lvl = 255;
        if (m_lvl < 0) m_lvl = 0;
      end else begin
        m_cnt = 0;
        m_dcnt++;
        if (m_dcnt == 16) begin
          m_dcnt = 0;
          if (m_lvl < 128) m_lvl++;
          else if (m_lvl > 128) m_lvl--;
        end
      end
    end
    m_zone = nz;
  endtask

  task automatic drive(input bit r, input bit t, input bit i, input bit d, input bit f);
    @(negedge clk);
    rst = r; bus.tick = t; bus.inc = i; bus.dec = d; bus.fast = f;
    @(posedge clk);
    model_edge(r, t, i, d, f);
    #1;
    check_eq("level",   int'(bus.level),   m_lvl);
    check_eq("level_q", int'(bus.level_q), m_zone);
    check_eq("at_max",  int'(bus.at_max),  (m_lvl == 255) ? 1 : 0);
    check_eq("at_min",  int'(bus.at_min),  (m_lvl == 0) ? 1 : 0);
  endtask

  task automatic tk(input bit i, input bit d, input bit f, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, i, d, f);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.tick = 1'b0; bus.inc = 1'b0; bus.dec = 1'b0; bus.fast = 1'b0;

    // Reset state
    do_rst();
    idle(5);
    check_eq("rst_level", int'(bus.level), 128);
    check_eq("rst_zone", int'(bus.level_q), 2);
    check_eq("rst_at_max", int'(bus.at_max), 0);
    check_eq("rst_at_min", int'(bus.at_min), 0);

    // Normal-rate UP
    tk(1'b1, 1'b0, 1'b0, 3);
    check_eq("norm_up_t3", int'(bus.level), 128);
    tk(1'b1, 1'b0, 1'b0, 1);
    check_eq("norm_up_t4", int'(bus.level), 129);
    tk(1'b1, 1'b0, 1'b0, 12);
    check_eq("norm_up_t16", int'(bus.level), 132);

    // Fast UP to the rail
    do_rst();
    tk(1'b1, 1'b0, 1'b1, 16);
    check_eq("fast_t16", int'(bus.level), 192);
    idle(1);
    check_eq("fast_zone3", int'(bus.level_q), 3);
    tk(1'b1, 1'b0, 1'b1, 16);
    check_eq("fast_t32", int'(bus.level), 255);
    check_eq("fast_at_max", int'(bus.at_max), 1);
    tk(1'b1, 1'b0, 1'b1, 1);
    check_eq("fast_t33", int'(bus.level), 255);

    // Hysteresis
    do_rst();
    tk(1'b1, 1'b0, 1'b1, 16);
    idle(1);
    tk(1'b0, 1'b1, 1'b1, 1);
    idle(1);
    check_eq("hyst_188_lvl", int'(bus.level), 188);
    check_eq("hyst_188_zone", int'(bus.level_q), 3);
    tk(1'b0, 1'b1, 1'b1, 2);
    idle(1);
    check_eq("hyst_180_lvl", int'(bus.level), 180);
    check_eq("hyst_180_zone", int'(bus.level_q), 2);
    tk(1'b1, 1'b0, 1'b1, 1);
    idle(1);
    check_eq("hyst_184_lvl", int'(bus.level), 184);
    check_eq("hyst_184_zone", int'(bus.level_q), 2);

    // Decay and conflicting commands
    do_rst();
    tk(1'b1, 1'b0, 1'b1, 3);
    check_eq("decay_start", int'(bus.level), 140);
    tk(1'b1, 1'b1, 1'b0, 15);
    check_eq("decay_t15", int'(bus.level), 140);
    tk(1'b1, 1'b1, 1'b1, 1);
    check_eq("decay_t16", int'(bus.level), 139);
    do_rst();
    tk(1'b1, 1'b1, 1'b0, 16);
    check_eq("decay_base", int'(bus.level), 128);

    // Direction change and mid-ramp reset
    do_rst();
    tk(1'b1, 1'b0, 1'b0, 3);
    tk(1'b0, 1'b1, 1'b0, 3);
    check_eq("dir_dec3", int'(bus.level), 128);
    tk(1'b0, 1'b1, 1'b0, 1);
    check_eq("dir_dec4", int'(bus.level), 127);
    tk(1'b1, 1'b0, 1'b0, 2);
    do_rst();
    check_eq("dir_rst", int'(bus.level), 128);
    tk(1'b1, 1'b0, 1'b0, 3);
    check_eq("dir_after_rst", int'(bus.level), 128);

    // Lower rail
    do_rst();
    tk(1'b0, 1'b1, 1'b1, 32);
    check_eq("min_lvl", int'(bus.level), 0);
    check_eq("min_at_min", int'(bus.at_min), 1);
    tk(1'b0, 1'b1, 1'b1, 1);
    check_eq("min_hold", int'(bus.level), 0);

    // Random bursts
    do_rst();
    for (int b = 0; b < 60; b++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int c = 0; c < 50; c++) begin
        bit r, t, i, d, f;
        int p;
        r = ($urandom_range(0, 299) == 0);
        t = ($urandom_range(0, 3) != 0);
        p = int'($urandom_range(0, 99));
        case (mode)
          0: begin i = (p < 85); d = (p >= 75); end
          1: begin d = (p < 85); i = (p >= 75); end
          2: begin i = (p < 40); d = i; end
          default: begin i = $urandom_range(0, 1) != 0; d = $urandom_range(0, 1) != 0; end
        endcase
        f = ($urandom_range(0, 9) < 3);
        drive(r, t, i, d, f);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neurotransmitter_level.md
# neurotransmitter_level

Stateful level integrator for one neurotransmitter. It consumes the `inc`/`dec`/`fast` command triple from that transmitter's regulator and keeps a saturating W-bit concentration register. With no drive, the register decays toward a baseline. It also produces the 2-bit quantized level (with hysteresis) that is packed into the shared `neurotransmitter_level[9:0]` bus read by all regulators. The design instantiates one copy per transmitter (CORT, DOP, GABA, NE, SER).

## Interface

- `WIDTH`, 8: width of the internal level register; must be ≥ 4.
- `BASELINE`, 128: reset value of the level and the target of idle decay.
- `PRESCALE`, 4: number of consecutive normal-rate active ticks per one-LSB step; power of two, ≥ 2.
- `STEP_FAST`, 4: step size applied on every fast tick.
- `DECAY_PERIOD`, 16: number of idle ticks per one-LSB decay step; power of two, ≥ 2.
- `HYST`, 8: downward hysteresis margin of the quantizer; must be < 2^(WIDTH-2).

Ports:

- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous reset, active-high.
- `tick`, in, 1: model time-step strobe, one `clk` wide; the level only changes on cycles where `tick`=1.
- `inc`, in, 1: regulator increase request.
- `dec`, in, 1: regulator decrease request.
- `fast`, in, 1: regulator fast-rate qualifier.
- `level`, out, WIDTH: registered concentration.
- `level_q`, out, 2: registered quantized level, 0..3.
- `at_max`, out, 1: high when `level` = 2^WIDTH−1.
- `at_min`, out, 1: high when `level` = 0.

## Operation

- **Command decode** on a cycle with `tick`=1:
  - UP: `inc` & !`dec`.
  - DOWN: `dec` & !`inc`.
  - IDLE: all other combinations, including `inc`&`dec`. `fast` is ignored when IDLE.
- **Normal rate**, UP or DOWN with `fast`=0:
  - `rate_cnt` (log2 PRESCALE bits) increments.
  - When `rate_cnt` = PRESCALE−1, it wraps to 0 and `level` moves by 1 in the requested direction.
  - The first step therefore lands on the PRESCALE-th consecutive same-direction tick.
- **Fast rate**, UP or DOWN with `fast`=1: `level` moves by STEP_FAST on every tick and `rate_cnt` is cleared.
- **Direction memory**:
  - A `last_dir` bit records the direction of the most recent UP/DOWN tick.
  - An active tick whose direction differs from `last_dir` clears `rate_cnt` before counting, so that tick counts as 1.
  - IDLE ticks clear `rate_cnt`.
- **Decay**:
  - IDLE ticks increment `decay_cnt`. At DECAY_PERIOD−1 it wraps and `level` moves 1 toward BASELINE.
  - No move occurs if `level` = BASELINE; the counter still wraps.
  - Any UP/DOWN tick clears `decay_cnt`.
- **Arithmetic**:
  - Sums are computed in WIDTH+1 bits.
  - An UP result above 2^WIDTH−1 clamps to 2^WIDTH−1.
  - A DOWN result below 0 clamps to 0.
  - No wrap-around is ever visible on `level`.
- **Quantizer**:
  - Thresholds are T1 = 2^(WIDTH−2), T2 = 2·T1, T3 = 3·T1.
  - Evaluated every `clk` against registered `level`, with current `level_q` = q.
  - Rise: if q<3 and `level` ≥ T(q+1), q ← q+1.
  - Fall: else if q>0 and `level` < T(q) − HYST, q ← q−1.
  - Otherwise q holds. At most one zone change per clk.
- **No tick** (`tick`=0): `level`, `rate_cnt`, `decay_cnt` and `last_dir` hold; only the quantizer may update.

## Timing

- **Reset** (`rst`=1 at a clk edge):
  - `level` = BASELINE.
  - `level_q` = zone of BASELINE with no hysteresis (2 for defaults).
  - `rate_cnt` = 0, `decay_cnt` = 0, `last_dir` = UP.
  - `at_max` = `at_min` = 0 for defaults.
- Reset wins over `tick` on the same edge. Reset mid-ramp discards all partial counts.
- **Latency**:
  - `level` changes on the edge that samples `tick`=1 and is visible the following cycle.
  - `at_max`/`at_min` are decoded directly from the `level` register and change in the same cycle as `level`.
  - `level_q` updates one cycle after `level` crosses a threshold, i.e. two cycles after the tick.
- **Inputs**: `inc`, `dec` and `fast` are sampled only on `tick` cycles and need only be stable at that edge. There is no handshake; the block always accepts.
- **Saturated level**: further same-direction ticks keep `level` at the rail. The counters keep running.

## Test plan

- **Reset**: `rst` for 1 cycle, then 5 idle cycles with `tick`=0 → `level`=128, `level_q`=2, `at_max`=0, `at_min`=0.
- **Normal UP**: `inc`=1, `fast`=0, `tick` every cycle → `level`=129 after the 4th tick and 132 after the 16th; no change on ticks 1–3.
- **Fast UP to rail**: `inc`=1, `fast`=1, `tick` every cycle →
  - `level`=192 after tick 16; `level_q`=3 one cycle later.
  - `level`=255 and `at_max`=1 after tick 32.
  - Tick 33 leaves `level`=255.
- **Hysteresis**: from `level`=192, `level_q`=3, apply `dec`+`fast`.
  - At 188, `level_q` stays 3.
  - At 180 (<184), `level_q`=2 on the next cycle.
  - Then a single UP fast tick back to 184 leaves `level_q`=2.
- **Decay and conflict**: `level`=140 with `inc`=`dec`=1 for 16 ticks → `level`=139. Repeating from `level`=128 gives no change.
- **Direction change and reset**:
  - 3 `inc` ticks, then 4 `dec` ticks (normal rate) from 128 → `level`=127.
  - Then 2 `inc` ticks, then `rst` → `level`=128; 3 more `inc` ticks give no change.
